// File: rtl/debug_pkg.sv
// Shared types and constants for the debug capture sequencer.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TRIG,
    CAPTURE,
    HEADER,
    FETCH,
    SEND
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  // Bytes needed to carry one buffer entry, rounded up.
  function automatic int calc_bytes(input int numwords, input int wordlen);
    return (numwords * wordlen + 7) / 8;
  endfunction

endpackage

// File: rtl/debug_ctrl_if.sv
// Buffer-port and byte-stream signals between the sequencer and its neighbours.
interface debug_ctrl_if #(
  parameter int WORDLEN  = 24,
  parameter int NUMWORDS = 2,
  parameter int ADDRW    = 12
);
  logic                        buf_we;
  logic [ADDRW-1:0]            buf_waddr;
  logic [ADDRW-1:0]            buf_raddr;
  logic [NUMWORDS*WORDLEN-1:0] buf_rdata;
  logic [7:0]                  tx_data;
  logic                        tx_valid;
  logic                        tx_ready;

  modport master (
    output buf_we, buf_waddr, buf_raddr, tx_data, tx_valid,
    input  buf_rdata, tx_ready
  );

  modport slave (
    input  buf_we, buf_waddr, buf_raddr, tx_data, tx_valid,
    output buf_rdata, tx_ready
  );
endinterface

// File: rtl/debug_trigger.sv
// Arm edge detector and signed level-crossing trigger for the capture sequencer.
module debug_trigger #(
  parameter int WORDLEN = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      idle,
  input  logic                      sampling,
  input  logic                      trig_mode,
  input  logic signed [WORDLEN-1:0] trig_level,
  input  logic                      data_in_valid,
  input  logic signed [WORDLEN-1:0] trig_sample,
  output logic                      arm_rise,
  output logic                      trig_hit
);

  logic                      arm_q;
  logic                      have_prev;
  logic signed [WORDLEN-1:0] prev;
  logic                      crossing;

  assign arm_rise = arm & ~arm_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q     <= 1'b0;
      prev      <= '0;
      have_prev <= 1'b0;
    end else begin
      arm_q <= arm;
      if (idle && arm_rise) begin
        prev      <= trig_level;
        have_prev <= 1'b0;
      end else if (sampling && data_in_valid) begin
        prev      <= trig_sample;
        have_prev <= 1'b1;
      end
    end
  end

  // The first sample after arming never counts as a crossing.
  assign crossing = have_prev && (prev <= trig_level) && (trig_sample > trig_level);
  assign trig_hit = data_in_valid && (!trig_mode || crossing);

endmodule

// File: rtl/debug_ctrl.sv
// Capture sequencer: trigger, fill the debug buffer, then stream it out as bytes.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int WORDLEN    = 24,
  parameter int NUMWORDS   = 2,
  parameter int ADDRW      = 12,
  parameter int RD_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      trig_mode,
  input  logic signed [WORDLEN-1:0] trig_level,
  input  logic                      data_in_valid,
  input  logic signed [WORDLEN-1:0] trig_sample,
  debug_ctrl_if.master              bus,
  output logic                      busy,
  output logic                      done
);

  localparam int BYTES = calc_bytes(NUMWORDS, WORDLEN);
  localparam int SHW   = BYTES * 8;
  localparam int LATW  = $clog2(RD_LATENCY + 1);
  localparam int BCW   = $clog2(BYTES + 1);
  localparam logic [ADDRW-1:0] LAST_ADDR = '1;

  state_t           state, state_next;
  logic [ADDRW-1:0] waddr, raddr;
  logic [SHW-1:0]   shreg;
  logic [LATW-1:0]  lat_cnt;
  logic [BCW-1:0]   byte_cnt;
  logic             hdr_sel;
  logic             we;
  logic             arm_rise, trig_hit;
  logic             fetch_load, last_byte;

  debug_trigger #(.WORDLEN(WORDLEN)) u_trigger (
    .clk           (clk),
    .reset         (reset),
    .arm           (arm),
    .idle          (state == IDLE),
    .sampling      (state == WAIT_TRIG),
    .trig_mode     (trig_mode),
    .trig_level    (trig_level),
    .data_in_valid (data_in_valid),
    .trig_sample   (trig_sample),
    .arm_rise      (arm_rise),
    .trig_hit      (trig_hit)
  );

  assign fetch_load = (lat_cnt == LATW'(RD_LATENCY));
  assign last_byte  = (byte_cnt == BCW'(BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    we         = 1'b0;
    unique case (state)
      IDLE:      if (arm_rise) state_next = WAIT_TRIG;
      WAIT_TRIG: if (trig_hit) begin
        we         = 1'b1;
        state_next = (waddr == LAST_ADDR) ? HEADER : CAPTURE;
      end
      CAPTURE:   if (data_in_valid) begin
        we = 1'b1;
        if (waddr == LAST_ADDR) state_next = HEADER;
      end
      HEADER:    if (bus.tx_ready && hdr_sel) state_next = FETCH;
      FETCH:     if (fetch_load) state_next = SEND;
      SEND:      if (bus.tx_ready && last_byte)
        state_next = (raddr == LAST_ADDR) ? IDLE : FETCH;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      waddr    <= '0;
      raddr    <= '0;
      shreg    <= '0;
      lat_cnt  <= '0;
      byte_cnt <= '0;
      hdr_sel  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && arm_rise) begin
        waddr   <= '0;
        raddr   <= '0;
        hdr_sel <= 1'b0;
      end
      if (we) waddr <= waddr + 1'b1;
      if (state == HEADER && bus.tx_ready) begin
        hdr_sel <= ~hdr_sel;
        if (hdr_sel) begin
          raddr   <= '0;
          lat_cnt <= '0;
        end
      end
      // raddr is held through FETCH; the load lands RD_LATENCY cycles in.
      if (state == FETCH) begin
        if (fetch_load) begin
          shreg    <= SHW'(bus.buf_rdata);
          byte_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
      end
      if (state == SEND && bus.tx_ready) begin
        if (last_byte) begin
          lat_cnt <= '0;
          if (raddr == LAST_ADDR) done  <= 1'b1;
          else                    raddr <= raddr + 1'b1;
        end else begin
          shreg    <= shreg << 8;
          byte_cnt <= byte_cnt + 1'b1;
        end
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.buf_we    = we;
  assign bus.buf_waddr = waddr;
  assign bus.buf_raddr = raddr;
  assign bus.tx_valid  = (state == HEADER) || (state == SEND);
  assign bus.tx_data   = (state == HEADER) ? (hdr_sel ? SYNC1 : SYNC0) :
                         (state == SEND)   ? shreg[SHW-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_debug_ctrl.sv
// Self-checking bench: behavioural buffer, sample/trigger model and byte-stream scoreboard.
module tb_debug_ctrl;

  localparam int WL     = 24;
  localparam int NW     = 2;
  localparam int AW     = 5;
  localparam int RDL    = 2;
  localparam int N      = 1 << AW;
  localparam int EW     = NW * WL;
  localparam int NBYTES = (EW + 7) / 8;
  localparam int SHW    = NBYTES * 8;
  localparam int BUDGET = 4000;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 arm = 1'b0;
  logic                 trig_mode = 1'b0;
  logic signed [WL-1:0] trig_level = '0;
  logic                 data_in_valid = 1'b0;
  logic signed [WL-1:0] trig_sample = '0;
  logic [EW-1:0]        data_in = '0;
  logic                 busy, done;

  debug_ctrl_if #(.WORDLEN(WL), .NUMWORDS(NW), .ADDRW(AW)) bus ();

  debug_ctrl #(.WORDLEN(WL), .NUMWORDS(NW), .ADDRW(AW), .RD_LATENCY(RDL)) dut (
    .clk           (clk),
    .reset         (reset),
    .arm           (arm),
    .trig_mode     (trig_mode),
    .trig_level    (trig_level),
    .data_in_valid (data_in_valid),
    .trig_sample   (trig_sample),
    .bus           (bus),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Behavioural buffer with RDL-cycle read latency.
  logic [EW-1:0] mem  [N];
  logic [EW-1:0] pipe [RDL];
  always @(posedge clk) begin
    if (bus.buf_we) mem[bus.buf_waddr] <= data_in;
    pipe[0] <= mem[bus.buf_raddr];
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.buf_rdata = pipe[RDL-1];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Observation queues filled mid-cycle.
  logic [AW-1:0] wr_addr_q [$];
  logic [EW-1:0] wr_data_q [$];
  int            wr_cyc_q  [$];
  logic [7:0]    tx_q      [$];
  logic [7:0]    saved_q   [$];
  int last_xfer_cyc, done_cnt, done_cyc, done_busy, stall_cnt, stall_viol;
  bit stalled;
  logic [7:0] stall_data;

  always @(negedge clk) begin
    if (bus.buf_we) begin
      wr_addr_q.push_back(bus.buf_waddr);
      wr_data_q.push_back(data_in);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.tx_valid && bus.tx_ready) begin
      tx_q.push_back(bus.tx_data);
      last_xfer_cyc = cyc;
    end
    if (stalled && !(bus.tx_valid && bus.tx_data == stall_data)) stall_viol++;
    stalled    = bus.tx_valid && !bus.tx_ready;
    stall_data = bus.tx_data;
    if (stalled) stall_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      if (busy) done_busy++;
    end
  end

  // Sample stream presented while the controller listens.
  logic signed [WL-1:0] smp_q [$];
  logic [WL-1:0]        w1_q  [$];
  logic signed [WL-1:0] pre_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); tx_q.delete();
    smp_q.delete(); w1_q.delete();
    done_cnt = 0; done_busy = 0; stall_cnt = 0; stall_viol = 0;
    stalled = 1'b0; last_xfer_cyc = -1; done_cyc = -1;
  endtask

  // kind: 0 ramp k, 1 random around level, 2 offset ramp 200+k, 3 fully random.
  task automatic run(input string name, input bit mode, input logic signed [WL-1:0] level,
                     input int kind, input int period, input bit bp, input bit noise,
                     input int abort_at);
    int k, ti, r;
    bit fin;
    logic signed [WL-1:0] s;
    logic [WL-1:0] w;
    logic [EW-1:0] e;
    logic [SHW-1:0] ext;
    logic [7:0] exp_q [$];

    clear_mon();
    trig_mode  = mode;
    trig_level = level;
    arm = 1'b1;
    step();
    arm = 1'b0;
    k   = 0;
    fin = 1'b0;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      if (abort_at > 0 && tx_q.size() >= abort_at && bus.tx_valid) begin
        check({name, "_busy_before_reset"}, busy, 1);
        reset = 1'b1;
        data_in_valid = 1'b0;
        step();
        reset = 1'b0;
        check({name, "_rst_busy"},  busy, 0);
        check({name, "_rst_valid"}, bus.tx_valid, 0);
        check({name, "_rst_data"},  bus.tx_data, 0);
        check({name, "_rst_waddr"}, bus.buf_waddr, 0);
        check({name, "_rst_raddr"}, bus.buf_raddr, 0);
        check({name, "_rst_done"},  done, 0);
        return;
      end
      data_in_valid = ((c % period) == 0);
      if (data_in_valid) begin
        if (k < pre_q.size()) s = pre_q[k];
        else begin
          unique case (kind)
            0: s = WL'(k);
            1: begin r = int'($urandom_range(0, 80)) - 40; s = level + WL'(r); end
            2: s = WL'(200 + k);
            default: s = WL'($urandom);
          endcase
        end
        w = (kind == 0 || kind == 2) ? WL'(k * 7 + 3) : WL'($urandom);
        smp_q.push_back(s);
        w1_q.push_back(w);
        trig_sample = s;
        data_in     = {w, s};
        k++;
      end else begin
        trig_sample = WL'($urandom);
        data_in     = EW'({$urandom, $urandom});
      end
      bus.tx_ready = bp ? (((c / 3) % 2) == 0) : 1'b1;
      if (noise) arm = (c >= 5 && c < 200) && (((c / 4) % 2) == 1);
      step();
      fin = (done_cnt > 0);
    end
    data_in_valid = 1'b0;
    arm           = 1'b0;
    bus.tx_ready  = 1'b1;
    repeat (4) step();
    check({name, "_finished"}, fin, 1);
    check({name, "_idle_after"}, busy, 0);

    // Reference: locate the trigger among the presented valid samples.
    ti = -1;
    for (int i = 0; i < smp_q.size(); i++) begin
      if (!mode || (i > 0 && smp_q[i-1] <= level && smp_q[i] > level)) begin
        ti = i;
        break;
      end
    end
    check({name, "_trigger_seen"}, (ti >= 0 && ti + N <= smp_q.size()), 1);
    if (ti < 0 || ti + N > smp_q.size()) return;

    check({name, "_wr_count"}, wr_addr_q.size(), N);
    for (int i = 0; i < N && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr_addr%0d", name, i), wr_addr_q[i], i);
      check($sformatf("%s_wr_data%0d", name, i), wr_data_q[i], {w1_q[ti+i], smp_q[ti+i]});
    end
    if (period == 1 && wr_cyc_q.size() == N)
      check({name, "_fill_cycles"}, wr_cyc_q[N-1] - wr_cyc_q[0], N - 1);

    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    for (int i = 0; i < N; i++) begin
      e   = {w1_q[ti+i], smp_q[ti+i]};
      ext = SHW'(e);
      for (int b = 0; b < NBYTES; b++) exp_q.push_back(ext[SHW-1-8*b -: 8]);
    end
    check({name, "_tx_count"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_tx%0d", name, i), tx_q[i], exp_q[i]);

    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_done_timing"}, done_cyc, last_xfer_cyc + 1);
    check({name, "_done_busy_low"}, done_busy, 0);
    if (bp) begin
      check({name, "_stalls_seen"}, (stall_cnt > 0), 1);
      check({name, "_stall_stable"}, stall_viol, 0);
    end
  endtask

  initial begin
    int diff;
    bus.tx_ready = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("reset_busy",  busy, 0);
    check("reset_done",  done, 0);
    check("reset_valid", bus.tx_valid, 0);
    check("reset_we",    bus.buf_we, 0);
    check("reset_waddr", bus.buf_waddr, 0);
    check("reset_raddr", bus.buf_raddr, 0);
    check("reset_data",  bus.tx_data, 0);

    // Immediate trigger on a ramp, full-rate stream.
    run("ramp", 1'b0, '0, 0, 1, 1'b0, 1'b0, 0);
    saved_q = tx_q;

    // Same stimulus under backpressure must yield the identical byte sequence.
    run("ramp_bp", 1'b0, '0, 0, 1, 1'b1, 1'b0, 0);
    diff = (saved_q.size() == tx_q.size()) ? 0 : 1;
    for (int i = 0; i < saved_q.size() && i < tx_q.size(); i++)
      if (saved_q[i] != tx_q[i]) diff++;
    check("bp_stream_identical", diff, 0);

    // Level mode: first sample 120 cannot fire, 90 -> 101 crosses.
    pre_q = '{WL'(120), WL'(90), WL'(101)};
    run("level_dir", 1'b1, WL'(100), 2, 1, 1'b0, 1'b0, 0);
    pre_q.delete();
    if (wr_data_q.size() > 0) check("level_first_sample", wr_data_q[0][WL-1:0], WL'(101));
    else                      check("level_first_present", wr_data_q.size(), 1);

    // Random samples around a negative threshold exercise the signed compare.
    run("level_rand", 1'b1, -WL'(5), 1, 1, 1'b0, 1'b0, 0);
    run("level_rand_bp", 1'b1, WL'(3000), 1, 2, 1'b1, 1'b0, 0);

    // arm toggling during CAPTURE and SEND must not restart anything.
    run("arm_noise", 1'b0, '0, 0, 1, 1'b0, 1'b1, 0);

    // Sparse valid, one sample every 8 cycles.
    run("sparse", 1'b0, '0, 3, 8, 1'b0, 1'b0, 0);

    // Reset mid-SEND with a byte pending, then a fresh capture from address 0.
    run("abort", 1'b0, '0, 3, 1, 1'b1, 1'b0, 20);
    repeat (2) step();
    run("after_abort", 1'b0, '0, 0, 1, 1'b0, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
